// File: rtl/bcd_a_binario_pkg.sv
// Shared types and constants for the three-digit BCD to binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    INACTIVO,
    CONVIRTIENDO,
    LISTO
  } estado_bcd_t;

  localparam int NUM_PASOS  = 12;
  localparam int VALOR_MAX  = 999;
  localparam int DIGITO_MAX = 9;
  localparam int ANCHO_BIN  = 10;

  function automatic logic hay_digito_invalido(input logic [11:0] bcd);
    return (bcd[11:8] > 4'(DIGITO_MAX)) ||
           (bcd[7:4]  > 4'(DIGITO_MAX)) ||
           (bcd[3:0]  > 4'(DIGITO_MAX));
  endfunction

endpackage

// File: rtl/bcd_a_binario_ajuste_digito.sv
// One reverse double-dabble correction: a shifted BCD digit of 8 or more
// carried a half-ten (8) that should weigh 5, so 3 is taken back out.
module ajuste_digito (
  input  logic [3:0] digito_i,
  output logic [3:0] digito_o
);

  assign digito_o = (digito_i >= 4'd8) ? digito_i - 4'd3 : digito_i;

endmodule

// File: rtl/bcd_a_binario.sv
// Sequential three-digit BCD to binary converter (0..999), one bit per
// clock using reverse double-dabble, with ready/valid on both sides.
module bcd_a_binario
  import bcd_pkg::*;
#(
  parameter int ANCHO_SALIDA = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    entrada_valida,
  output logic                    entrada_lista,
  input  logic [3:0]              centenas,
  input  logic [3:0]              decenas,
  input  logic [3:0]              unidades,
  output logic                    salida_valida,
  input  logic                    salida_lista,
  output logic [ANCHO_SALIDA-1:0] valor,
  output logic                    error_bcd
);

  estado_bcd_t             estado_q, estado_d;
  logic [11:0]             bcd_q, bcd_d;
  logic [ANCHO_BIN-1:0]    bin_q, bin_d;
  logic [3:0]              paso_q, paso_d;
  logic [ANCHO_SALIDA-1:0] valor_q, valor_d;
  logic                    error_q, error_d;

  logic [11+ANCHO_BIN:0]   desplazado;
  logic [11:0]             bcd_ajustado;

  assign desplazado = {bcd_q, bin_q} >> 1;

  for (genvar i = 0; i < 3; i++) begin : g_ajuste
    ajuste_digito u_ajuste (
      .digito_i(desplazado[ANCHO_BIN+4*i +: 4]),
      .digito_o(bcd_ajustado[4*i +: 4])
    );
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    estado_d = estado_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    paso_d   = paso_q;
    valor_d  = valor_q;
    error_d  = error_q;

    case (estado_q)
      INACTIVO: begin
        if (entrada_valida) begin
          bcd_d  = {centenas, decenas, unidades};
          bin_d  = '0;
          paso_d = '0;
          if (hay_digito_invalido({centenas, decenas, unidades})) begin
            error_d  = 1'b1;
            valor_d  = '0;
            estado_d = LISTO;
          end else begin
            error_d  = 1'b0;
            estado_d = CONVIRTIENDO;
          end
        end
      end

      CONVIRTIENDO: begin
        bcd_d  = bcd_ajustado;
        // After ANCHO_BIN shifts the BCD side is empty (value < 1024); shifting
        // further would push the result LSBs out of the 10-bit register.
        if (paso_q < 4'(ANCHO_BIN)) bin_d = desplazado[ANCHO_BIN-1:0];
        paso_d = paso_q + 4'd1;
        if (paso_q == 4'(NUM_PASOS - 1)) begin
          valor_d                = '0;
          valor_d[ANCHO_BIN-1:0] = bin_d;
          paso_d                 = '0;
          estado_d               = LISTO;
        end
      end

      LISTO: begin
        if (salida_lista) estado_d = INACTIVO;
      end

      default: estado_d = INACTIVO;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= INACTIVO;
      bcd_q    <= '0;
      bin_q    <= '0;
      paso_q   <= '0;
      valor_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      paso_q   <= paso_d;
      valor_q  <= valor_d;
      error_q  <= error_d;
    end
  end

  assign entrada_lista = (estado_q == INACTIVO);
  assign salida_valida = (estado_q == LISTO);
  assign valor         = valor_q;
  assign error_bcd     = error_q;

endmodule
